// File: rtl/sd_spi_data_rx_if.sv
// Byte-stream and status bundle between the SD SPI controller/sink and the data-block receiver.
// The slave modport is the receiver side.
interface sd_spi_data_rx_if #(
    parameter int IDX_W = 9
) ();
    logic             start;
    logic             sclk_rise;
    logic             miso;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic [IDX_W-1:0] byte_index;
    logic             busy;
    logic             done;
    logic             crc_ok;
    logic             timeout;
    logic             token_err;
    logic [3:0]       err_flags;

    modport master (
        output start, sclk_rise, miso,
        input  byte_data, byte_valid, byte_index, busy, done,
        input  crc_ok, timeout, token_err, err_flags
    );

    modport slave (
        input  start, sclk_rise, miso,
        output byte_data, byte_valid, byte_index, busy, done,
        output crc_ok, timeout, token_err, err_flags
    );
endinterface

// File: rtl/sd_spi_data_rx.sv
// SPI-mode SD single data block receiver: start-token hunt, byte delivery and CRC16 check.
// Every bit-level step is gated by the sclk_rise strobe from the SD command controller.
module sd_spi_data_rx #(
    parameter int BLOCK_BYTES   = 512,
    parameter int TIMEOUT_BYTES = 1024,
    parameter int IDX_W         = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1
) (
    input  logic           clk,
    input  logic           rst,
    sd_spi_data_rx_if.slave bus
);
    localparam int SLOT_W = $clog2(TIMEOUT_BYTES + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [SLOT_W-1:0] SLOT_LIMIT = SLOT_W'(TIMEOUT_BYTES);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(TIMEOUT_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HUNT, S_DATA, S_CRC, S_CHECK, S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [IDX_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [15:0]       crc_q, crc_d;
    logic [15:0]       rx_crc_q, rx_crc_d;
    logic [7:0]        byte_data_q, byte_data_d;
    logic              byte_valid_q, byte_valid_d;
    logic [IDX_W-1:0]  byte_index_q, byte_index_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              crc_ok_q, crc_ok_d;
    logic              timeout_q, timeout_d;
    logic              token_err_q, token_err_d;
    logic [3:0]        err_flags_q, err_flags_d;
    logic [7:0]        slot_s;

    // One serial step of CRC16-CCITT (0x1021), MSB first.
    function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return fb ? ({crc[14:0], 1'b0} ^ 16'h1021) : {crc[14:0], 1'b0};
    endfunction

    assign slot_s = {shift_q[6:0], bus.miso};

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        slot_cnt_d   = slot_cnt_q;
        crc_d        = crc_q;
        rx_crc_d     = rx_crc_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        byte_index_d = byte_index_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        crc_ok_d     = crc_ok_q;
        timeout_d    = timeout_q;
        token_err_d  = token_err_q;
        err_flags_d  = err_flags_q;

        case (state_q)
            S_IDLE: begin
                // A strobe coincident with start is deliberately not sampled.
                if (bus.start) begin
                    state_d     = S_HUNT;
                    busy_d      = 1'b1;
                    bit_cnt_d   = 4'd0;
                    shift_d     = 8'h00;
                    byte_cnt_d  = '0;
                    slot_cnt_d  = '0;
                    crc_d       = 16'h0000;
                    rx_crc_d    = 16'h0000;
                    crc_ok_d    = 1'b0;
                    timeout_d   = 1'b0;
                    token_err_d = 1'b0;
                    err_flags_d = 4'h0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HUNT: begin
                if (bus.sclk_rise) begin
                    shift_d = slot_s;
                    if (bit_cnt_q[2:0] == 3'd7) begin
                        bit_cnt_d = 4'd0;
                        if (slot_s == 8'hFE) begin
                            state_d = S_DATA;
                        end else if (slot_s[7:4] == 4'b0000) begin
                            token_err_d = 1'b1;
                            err_flags_d = slot_s[3:0];
                            state_d     = S_FINISH;
                        end else if (slot_cnt_q == SLOT_LAST) begin
                            slot_cnt_d = SLOT_LIMIT;
                            timeout_d  = 1'b1;
                            state_d    = S_FINISH;
                        end else begin
                            slot_cnt_d = slot_cnt_q + SLOT_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = S_HUNT;
                end
            end
            S_DATA: begin
                if (bus.sclk_rise) begin
                    shift_d = slot_s;
                    crc_d   = crc16_bit(crc_q, bus.miso);
                    if (bit_cnt_q[2:0] == 3'd7) begin
                        bit_cnt_d    = 4'd0;
                        byte_valid_d = 1'b1;
                        byte_data_d  = slot_s;
                        byte_index_d = byte_cnt_q;
                        if (byte_cnt_q == LAST_IDX) begin
                            state_d = S_CRC;
                        end else begin
                            byte_cnt_d = byte_cnt_q + IDX_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CRC: begin
                // crc_q is no longer updated here, so it holds the computed value.
                if (bus.sclk_rise) begin
                    rx_crc_d = {rx_crc_q[14:0], bus.miso};
                    if (bit_cnt_q == 4'd15) begin
                        bit_cnt_d = 4'd0;
                        state_d   = S_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = S_CRC;
                end
            end
            S_CHECK: begin
                crc_ok_d = (rx_crc_q == crc_q);
                state_d  = S_FINISH;
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_FINISH);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            byte_cnt_q   <= '0;
            slot_cnt_q   <= '0;
            crc_q        <= 16'h0000;
            rx_crc_q     <= 16'h0000;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            byte_index_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            crc_ok_q     <= 1'b0;
            timeout_q    <= 1'b0;
            token_err_q  <= 1'b0;
            err_flags_q  <= 4'h0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            slot_cnt_q   <= slot_cnt_d;
            crc_q        <= crc_d;
            rx_crc_q     <= rx_crc_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            byte_index_q <= byte_index_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            crc_ok_q     <= crc_ok_d;
            timeout_q    <= timeout_d;
            token_err_q  <= token_err_d;
            err_flags_q  <= err_flags_d;
        end
    end

    assign bus.byte_data  = byte_data_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_index = byte_index_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.crc_ok     = crc_ok_q;
    assign bus.timeout    = timeout_q;
    assign bus.token_err  = token_err_q;
    assign bus.err_flags  = err_flags_q;
endmodule

// File: tb/tb_sd_spi_data_rx.sv
// Bench for sd_spi_data_rx: randomized strobe spacing and data, outcomes predicted by a
// byte-level model of the SD data-block format with a reference CRC16-CCITT.
`timescale 1ns/1ps
module tb_sd_spi_data_rx;
    localparam int BLOCK_BYTES   = 512;
    localparam int TIMEOUT_BYTES = 1024;
    localparam int IDX_W         = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sd_spi_data_rx_if #(.IDX_W(IDX_W)) bus ();

    sd_spi_data_rx #(.BLOCK_BYTES(BLOCK_BYTES), .TIMEOUT_BYTES(TIMEOUT_BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_strobe_cyc = 0;
    logic [7:0] got_data[$];
    int         got_idx[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Collect delivered bytes and done pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.byte_valid === 1'b1) begin
            got_data.push_back(bus.byte_data);
            got_idx.push_back(int'(bus.byte_index));
        end
        if (bus.done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference CRC16-CCITT over a byte list: poly 0x1021, init 0, MSB first.
    function automatic logic [15:0] ref_crc(input logic [7:0] d[$]);
        logic [15:0] c;
        c = 16'h0000;
        foreach (d[i]) begin
            for (int b = 7; b >= 0; b--) begin
                if (c[15] ^ d[i][b]) c = (c << 1) ^ 16'h1021;
                else                  c = c << 1;
            end
        end
        return c;
    endfunction

    // Outcome of feeding a slot stream to a receiver: token hunt, data block, CRC compare.
    task automatic model(input logic [7:0] s[$], output logic [7:0] d[$], output bit e_ok,
                         output bit e_to, output bit e_tok, output logic [3:0] e_fl,
                         output bit e_crc_path);
        int slots;
        logic [15:0] rx;
        d = {}; e_ok = 0; e_to = 0; e_tok = 0; e_fl = 4'h0; e_crc_path = 0; slots = 0;
        for (int k = 0; k < s.size(); k++) begin
            if (s[k] == 8'hFE) begin
                for (int i = 0; i < BLOCK_BYTES; i++) d.push_back(s[k + 1 + i]);
                rx = {s[k + 1 + BLOCK_BYTES], s[k + 2 + BLOCK_BYTES]};
                e_ok = (ref_crc(d) == rx);
                e_crc_path = 1;
                return;
            end else if (s[k] < 8'h10) begin
                e_tok = 1;
                e_fl = s[k][3:0];
                return;
            end else begin
                slots++;
                if (slots == TIMEOUT_BYTES) begin
                    e_to = 1;
                    return;
                end
            end
        end
    endtask

    task automatic send_bit(input logic b);
        int gap;
        bus.miso = b;
        bus.sclk_rise = 1'b1;
        last_strobe_cyc = cyc;
        @(posedge clk); #1;
        bus.sclk_rise = 1'b0;
        bus.miso = 1'($urandom);
        gap = $urandom_range(0, 1);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic pulse_start(input logic with_strobe);
        bus.start = 1'b1;
        bus.sclk_rise = with_strobe;
        bus.miso = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.sclk_rise = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 40) begin @(posedge clk); #1; n++; end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // Full transfer of a slot stream; optional extra start after stream byte restart_at.
    task automatic run_block(input string name, input logic [7:0] s[$], input int restart_at);
        logic [7:0] exp_d[$];
        bit e_ok, e_to, e_tok, e_crc_path;
        logic [3:0] e_fl;
        int d0, b0, lat, nb;
        model(s, exp_d, e_ok, e_to, e_tok, e_fl, e_crc_path);
        d0 = done_cnt;
        b0 = got_data.size();
        pulse_start(1'b1);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_start: got %b want 1", name, bus.busy);
        end
        for (int k = 0; k < s.size(); k++) begin
            send_byte(s[k]);
            if (k == restart_at) pulse_start(1'b0);
        end
        wait_done(d0);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt - d0);
        end
        lat = done_cyc - last_strobe_cyc;
        checks++;
        if (e_crc_path ? (lat != 2) : (lat < 1 || lat > 2)) begin
            errors++; $display("FAIL %s done_latency: got %0d want %0d", name, lat, e_crc_path ? 2 : 1);
        end
        checks++;
        if ({bus.crc_ok, bus.timeout, bus.token_err, bus.err_flags} !== {e_ok, e_to, e_tok, e_fl}) begin
            errors++;
            $display("FAIL %s status: got ok=%b to=%b tok=%b fl=%h want ok=%b to=%b tok=%b fl=%h", name,
                     bus.crc_ok, bus.timeout, bus.token_err, bus.err_flags, e_ok, e_to, e_tok, e_fl);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL %s busy_after_done: got %b want 0", name, bus.busy);
        end
        nb = got_data.size() - b0;
        checks++;
        if (nb != exp_d.size()) begin
            errors++; $display("FAIL %s byte_count: got %0d want %0d", name, nb, exp_d.size());
        end
        for (int i = 0; i < nb && i < exp_d.size(); i++) begin
            checks++;
            if (got_data[b0 + i] !== exp_d[i] || got_idx[b0 + i] != i) begin
                errors++;
                $display("FAIL %s byte[%0d]: got data=%h idx=%0d want data=%h idx=%0d", name, i,
                         got_data[b0 + i], got_idx[b0 + i], exp_d[i], i);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.sclk_rise = 1'b0; bus.miso = 1'b1;
        #2;
        checks++;
        if ({bus.byte_data, bus.byte_valid, bus.byte_index, bus.busy, bus.done, bus.crc_ok,
             bus.timeout, bus.token_err, bus.err_flags} !== '0) begin
            errors++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_ff_block(input logic [15:0] crc, input string name);
        logic [7:0] s[$];
        s = {8'hFF, 8'hFF, 8'hFF, 8'hFE};
        for (int i = 0; i < BLOCK_BYTES; i++) s.push_back(8'hFF);
        s.push_back(crc[15:8]); s.push_back(crc[7:0]);
        run_block(name, s, -1);
    endtask

    task automatic test_zero_block;
        logic [7:0] s[$];
        s = {8'hFE};
        for (int i = 0; i < BLOCK_BYTES + 2; i++) s.push_back(8'h00);
        run_block("zero_block", s, -1);
    endtask

    task automatic test_incr_block;
        logic [7:0] s[$];
        logic [7:0] d[$];
        logic [15:0] c;
        int b0;
        for (int i = 0; i < BLOCK_BYTES; i++) d.push_back(8'(i));
        c = ref_crc(d);
        s = {8'hFE};
        s = {s, d};
        s.push_back(c[15:8]); s.push_back(c[7:0]);
        b0 = got_data.size();
        run_block("incr_block", s, -1);
        for (int i = b0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== 8'(got_idx[i])) begin
                errors++; $display("FAIL incr_data_vs_index: got %h want %h", got_data[i], 8'(got_idx[i]));
            end
        end
    endtask

    task automatic test_timeout;
        int d0, b0, lat;
        d0 = done_cnt;
        b0 = got_data.size();
        pulse_start(1'b1);
        for (int i = 0; i < TIMEOUT_BYTES - 1; i++) send_byte(8'hFF);
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (done_cnt != d0) begin
            errors++; $display("FAIL timeout_early_done: got %0d pulses want 0", done_cnt - d0);
        end
        send_byte(8'hFF);
        wait_done(d0);
        lat = done_cyc - last_strobe_cyc;
        checks++;
        if (done_cnt - d0 != 1 || lat < 1 || lat > 2) begin
            errors++; $display("FAIL timeout_done: got count=%0d lat=%0d want 1 and 1..2", done_cnt - d0, lat);
        end
        checks++;
        if ({bus.timeout, bus.token_err, bus.crc_ok} !== 3'b100) begin
            errors++; $display("FAIL timeout_status: got to/tok/ok=%b%b%b want 100",
                               bus.timeout, bus.token_err, bus.crc_ok);
        end
        checks++;
        if (got_data.size() != b0) begin
            errors++; $display("FAIL timeout_bytes: got %0d want 0", got_data.size() - b0);
        end
    endtask

    task automatic test_token_err;
        logic [7:0] s[$];
        s = {8'hFF, 8'h09};
        run_block("token_09", s, -1);
    endtask

    task automatic test_random;
        logic [7:0] s[$];
        logic [7:0] v;
        logic [7:0] d[$];
        logic [15:0] c;
        int pre;
        for (int r = 0; r < 2; r++) begin
            s = {};
            pre = $urandom_range(0, 5);
            for (int i = 0; i < pre; i++) begin
                v = 8'($urandom_range(16, 255));
                if (v == 8'hFE) v = 8'hFD;
                s.push_back(v);
            end
            s.push_back(8'($urandom_range(0, 15)));
            run_block("rand_token", s, -1);
        end
        s = {8'hA5, 8'hFE};
        d = {};
        for (int i = 0; i < BLOCK_BYTES; i++) d.push_back(8'($urandom));
        c = ref_crc(d);
        if ($urandom_range(0, 1) == 1) c = c ^ (16'h1 << $urandom_range(0, 15));
        s = {s, d};
        s.push_back(c[15:8]); s.push_back(c[7:0]);
        run_block("rand_block", s, -1);
    endtask

    task automatic test_reset_mid_and_restart;
        logic [7:0] s[$];
        logic [7:0] d[$];
        logic [15:0] c;
        int d0, b0;
        d0 = done_cnt;
        b0 = got_data.size();
        pulse_start(1'b1);
        send_byte(8'hFE);
        for (int i = 0; i <= 100; i++) send_byte(8'($urandom));
        @(posedge clk); #1;
        checks++;
        if (got_data.size() - b0 != 101) begin
            errors++; $display("FAIL pre_reset_bytes: got %0d want 101", got_data.size() - b0);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.byte_data, bus.byte_valid, bus.byte_index, bus.busy, bus.done, bus.crc_ok,
             bus.timeout, bus.token_err, bus.err_flags} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got nonzero outputs, want all 0");
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        checks++;
        if (done_cnt != d0) begin
            errors++; $display("FAIL mid_reset_done: got %0d pulses want 0", done_cnt - d0);
        end
        d = {};
        for (int i = 0; i < BLOCK_BYTES; i++) d.push_back(8'($urandom));
        c = ref_crc(d);
        s = {8'hFF, 8'hFE};
        s = {s, d};
        s.push_back(c[15:8]); s.push_back(c[7:0]);
        run_block("restart_block", s, 200);
    endtask

    initial begin
        test_reset();
        test_ff_block(16'h7FA1, "ff_block_good_crc");
        test_ff_block(16'h7FA0, "ff_block_bad_crc");
        test_zero_block();
        test_incr_block();
        test_timeout();
        test_token_err();
        test_random();
        test_reset_mid_and_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
